// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle control sequencer: FSM states, op classes
// and default parameter values.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5
  } state_type;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_BRANCH = 2'd3
  } op_class_t;

  localparam int unsigned CNT_W_DEFAULT   = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TO_W_DEFAULT    = 8;

  function automatic logic op_uses_memory(op_class_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic dmem_we;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_counter.sv
// Wrap-around up-counter with synchronous clear (clear wins over increment).
module ctrl_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: per-op-class step paths, memory stalls with
// timeout, flush, run/halt and cycle/retire performance counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = TO_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 flush,
    input  op_class_t            op_class,
    multicycle_ctrl_if.master    mem,
    output state_type            state,
    output logic                 ir_we,
    output logic                 exec_en,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     retire_cnt
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_type        r_state;
    state_type        w_next;
    op_class_t        r_op;
    logic             r_err;
    logic             r_blocked;
    logic [TO_W-1:0]  w_stall_cnt;
    logic             w_stalled;
    logic             w_timeout;
    logic             w_retire;
    logic             w_stall_inc;
    logic             w_stall_clr;

    always_comb begin
        w_next       = r_state;
        w_stalled    = 1'b0;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        exec_en      = 1'b0;
        rf_we        = 1'b0;

        case (r_state)
            IDLE: begin
                if (run && !r_blocked) w_next = FETCH;
            end
            FETCH: begin
                mem.imem_req = 1'b1;
                w_stalled    = !mem.imem_ready;
                if (mem.imem_ready) begin
                    ir_we  = 1'b1;
                    w_next = DECODE;
                end
            end
            DECODE: begin
                w_next = EXECUTE;
            end
            EXECUTE: begin
                exec_en = 1'b1;
                case (r_op)
                    OP_ALU:    w_next = WRITEBACK;
                    OP_BRANCH: w_retire = 1'b1;
                    default:   w_next = MEMORY;
                endcase
            end
            MEMORY: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (r_op == OP_STORE);
                w_stalled    = !mem.dmem_ready;
                if (mem.dmem_ready) begin
                    if (r_op == OP_STORE) w_retire = 1'b1;
                    else                  w_next   = WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we    = 1'b1;
                w_retire = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        w_timeout = (TIMEOUT != 0) && w_stalled && (w_stall_cnt == TO_LAST);

        if (w_retire)  w_next = run ? FETCH : IDLE;
        if (w_timeout) w_next = IDLE;

        // Flush overrides every ready/run/timeout decision and squashes side effects.
        if (flush && (r_state != IDLE)) begin
            w_next       = FETCH;
            w_retire     = 1'b0;
            w_timeout    = 1'b0;
            mem.dmem_req = 1'b0;
            ir_we        = 1'b0;
            rf_we        = 1'b0;
        end

        pc_we       = w_retire;
        busy        = (r_state != IDLE);
        w_stall_inc = w_stalled;
        w_stall_clr = !w_stalled || w_timeout || (flush && (r_state != IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= OP_ALU;
            r_err     <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_op <= op_class;
            // After a timeout, run must be seen low before IDLE may leave again.
            if (w_timeout) begin
                r_err     <= 1'b1;
                r_blocked <= 1'b1;
            end else if (!run) begin
                r_blocked <= 1'b0;
            end
        end
    end

    assign state = r_state;
    assign err   = r_err;

    ctrl_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (busy),
        .clr   (1'b0),
        .cnt   (cycle_cnt)
    );

    ctrl_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_we),
        .clr   (1'b0),
        .cnt   (retire_cnt)
    );

    ctrl_counter #(.W(TO_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (w_stall_clr),
        .cnt   (w_stall_cnt)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random traffic, checked
// every cycle against a step-list model of each instruction's path.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 4;
    localparam int TB_WRAP    = 1 << TB_CNT_W;

    logic                clk;
    logic                reset;
    logic                run;
    logic                flush;
    op_class_t           op_class;
    state_type           state;
    logic                ir_we, exec_en, rf_we, pc_we, busy, err;
    logic [TB_CNT_W-1:0] cycle_cnt, retire_cnt;

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl #(
        .CNT_W   (TB_CNT_W),
        .TIMEOUT (TB_TIMEOUT),
        .TO_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .flush      (flush),
        .op_class   (op_class),
        .mem        (mem_if),
        .state      (state),
        .ir_we      (ir_we),
        .exec_en    (exec_en),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .busy       (busy),
        .err        (err),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an instruction is a list of step letters, F D E then M/W by op class.
    byte       m_path[$];
    int        m_idx;
    bit        m_busy;
    op_class_t m_op;
    int        m_stall;
    bit        m_err;
    bit        m_blocked;
    int        m_cyc;
    int        m_ret;

    int n_rf, n_pc, n_we, n_dreq;

    task automatic model_reset();
        m_path.delete();
        m_idx = 0; m_busy = 0; m_op = OP_ALU; m_stall = 0;
        m_err = 0; m_blocked = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic new_instr();
        m_path.delete();
        m_path.push_back("F");
        m_path.push_back("D");
        m_path.push_back("E");
        m_idx  = 0;
        m_busy = 1;
    endtask

    function automatic state_type step_state(byte c);
        case (c)
            "F":     return FETCH;
            "D":     return DECODE;
            "E":     return EXECUTE;
            "M":     return MEMORY;
            "W":     return WRITEBACK;
            default: return IDLE;
        endcase
    endfunction

    task automatic clear_obs();
        n_rf = 0; n_pc = 0; n_we = 0; n_dreq = 0;
    endtask

    task automatic cyc(input bit run_i, input bit flush_i, input op_class_t op_i,
                       input bit ir_i, input bit dr_i);
        byte cur;
        bit  stalled, fl, tmo, last, retire, start;
        @(negedge clk);
        run = run_i; flush = flush_i; op_class = op_i;
        mem_if.imem_ready = ir_i; mem_if.dmem_ready = dr_i;
        #1;
        cur     = m_busy ? m_path[m_idx] : "I";
        stalled = (cur == "F" && !ir_i) || (cur == "M" && !dr_i);
        fl      = m_busy && flush_i;
        tmo     = m_busy && !fl && stalled && (m_stall + 1 == TB_TIMEOUT);
        last    = m_busy && (m_idx == m_path.size() - 1) && (cur != "D");
        retire  = m_busy && !fl && !stalled && last;

        chk("state",    32'(state),            32'(step_state(cur)));
        chk("busy",     32'(busy),             32'(m_busy));
        chk("imem_req", 32'(mem_if.imem_req),  32'(cur == "F"));
        chk("dmem_req", 32'(mem_if.dmem_req),  32'(cur == "M" && !fl));
        chk("dmem_we",  32'(mem_if.dmem_we),   32'(cur == "M" && m_op == OP_STORE));
        chk("ir_we",    32'(ir_we),            32'(cur == "F" && ir_i && !fl));
        chk("exec_en",  32'(exec_en),          32'(cur == "E"));
        chk("rf_we",    32'(rf_we),            32'(cur == "W" && !fl));
        chk("pc_we",    32'(pc_we),            32'(retire));
        chk("err",      32'(err),              32'(m_err));
        chk("cycle_cnt",  32'(cycle_cnt),      32'(m_cyc));
        chk("retire_cnt", 32'(retire_cnt),     32'(m_ret));

        n_rf   += int'(rf_we);
        n_pc   += int'(pc_we);
        n_we   += int'(mem_if.dmem_we);
        n_dreq += int'(mem_if.dmem_req);

        if (m_busy) m_cyc = (m_cyc + 1) % TB_WRAP;
        if (retire) m_ret = (m_ret + 1) % TB_WRAP;
        start = !m_busy && run_i && !m_blocked;
        if (tmo) m_blocked = 1;
        else if (!run_i) m_blocked = 0;

        if (!m_busy) begin
            m_stall = 0;
            if (start) new_instr();
        end else if (fl) begin
            m_stall = 0;
            new_instr();
        end else if (tmo) begin
            m_err = 1; m_busy = 0; m_stall = 0;
        end else if (stalled) begin
            m_stall++;
        end else begin
            m_stall = 0;
            if (cur == "D") begin
                m_op = op_i;
                case (op_i)
                    OP_ALU:   m_path.push_back("W");
                    OP_LOAD:  begin m_path.push_back("M"); m_path.push_back("W"); end
                    OP_STORE: m_path.push_back("M");
                    default:  ;
                endcase
            end
            if (retire) begin
                if (run_i) new_instr();
                else m_busy = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; flush = 1'b0; op_class = OP_ALU;
        mem_if.imem_ready = 1'b0; mem_if.dmem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted between edges while in MEMORY
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 0);
        @(posedge clk);
        #2;
        chk("pre_reset_state", 32'(state), 32'(MEMORY));
        reset = 1'b1; run = 1'b0;
        #1;
        chk("async_state",  32'(state), 32'(IDLE));
        chk("async_outs",   {25'd0, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we,
                             ir_we, exec_en, rf_we, pc_we}, 32'd0);
        chk("async_busy",   32'(busy), 32'd0);
        chk("async_cnts",   {24'd0, cycle_cnt, retire_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // ALU with zero-wait memory
        clear_obs();
        cyc(1, 0, OP_ALU, 1, 1);
        repeat (4) cyc(1, 0, OP_ALU, 1, 1);
        after_edge();
        chk("alu_retire_cnt", 32'(retire_cnt), 32'd1);
        chk("alu_state", 32'(state), 32'(FETCH));
        chk("alu_pc_we_count", 32'(n_pc), 32'd1);

        // LOAD with three data-memory wait cycles
        clear_obs();
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 1);
        repeat (3) cyc(1, 0, OP_LOAD, 1, 0);
        cyc(1, 0, OP_LOAD, 1, 1);
        cyc(1, 0, OP_LOAD, 1, 1);
        after_edge();
        chk("load_dreq_cycles", 32'(n_dreq), 32'd4);
        chk("load_rf_we_count", 32'(n_rf), 32'd1);
        chk("load_retire_cnt",  32'(retire_cnt), 32'd2);

        // BRANCH then STORE back to back
        clear_obs();
        repeat (3) cyc(1, 0, OP_BRANCH, 1, 1);
        repeat (4) cyc(1, 0, OP_STORE, 1, 1);
        after_edge();
        chk("bs_rf_we_count",   32'(n_rf), 32'd0);
        chk("bs_dmem_we_count", 32'(n_we), 32'd1);
        chk("bs_pc_we_count",   32'(n_pc), 32'd2);
        chk("bs_retire_cnt",    32'(retire_cnt), 32'd4);

        // Flush in WRITEBACK
        clear_obs();
        repeat (3) cyc(1, 0, OP_ALU, 1, 1);
        cyc(1, 1, OP_ALU, 1, 1);
        after_edge();
        chk("flush_rf_we_count", 32'(n_rf), 32'd0);
        chk("flush_pc_we_count", 32'(n_pc), 32'd0);
        chk("flush_state",       32'(state), 32'(FETCH));
        chk("flush_retire_cnt",  32'(retire_cnt), 32'd4);

        // Fetch stall timeout, restart by dropping run, then retire_cnt wrap
        repeat (4) cyc(1, 0, OP_ALU, 0, 0);
        after_edge();
        chk("timeout_err",   32'(err), 32'd1);
        chk("timeout_state", 32'(state), 32'(IDLE));
        repeat (2) cyc(1, 0, OP_ALU, 1, 1);
        after_edge();
        chk("blocked_state", 32'(state), 32'(IDLE));
        cyc(0, 0, OP_ALU, 1, 1);
        cyc(1, 0, OP_ALU, 1, 1);
        repeat (12 * 3) cyc(1, 0, OP_BRANCH, 1, 1);
        after_edge();
        chk("wrap_retire_cnt", 32'(retire_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 31) == 0,
                op_class_t'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
